// File: rtl/fpga_gpio_bank.sv
// GPIO bank: DO/OE pad drive, 2-flop synchronised inputs, debounced DI, edge-detect interrupts (GPIO_DEBOUNCE_EN adds per-channel debounce).
// Latency: register access completes in 1 cycle; pad-to-DI 3+DEB cycles (3 without GPIO_DEBOUNCE_EN); irq_o lags IP/IE by 1 cycle.
// Backpressure: requester holds reg_valid_i until reg_ready_o; one access accepted every second cycle.
module fpga_gpio_bank #(
    parameter int GPIO_NUM  = 16,
    parameter int DEB_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                reg_valid_i,
    output logic                reg_ready_o,
    input  logic                reg_we_i,
    input  logic [2:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_oe_o,
    output logic                irq_o
);
    localparam logic [2:0] A_DO   = 3'd0;
    localparam logic [2:0] A_OE   = 3'd1;
    localparam logic [2:0] A_DI   = 3'd2;
    localparam logic [2:0] A_IE   = 3'd3;
    localparam logic [2:0] A_IP   = 3'd4;
    localparam logic [2:0] A_EDGE = 3'd5;
    localparam logic [2:0] A_DEB  = 3'd6;

    logic [GPIO_NUM-1:0] do_r, oe_r, ie_r, ip_r, edge_r;
    logic [GPIO_NUM-1:0] sync1_r, sync2_r, stable_r;
    logic [GPIO_NUM-1:0] stable_nxt, edge_ev, ip_clr, wdata_g;
    logic                acc, wr;
    logic [31:0]         rd_mux, deb_rd;
    logic                unused_wdata;

    // An access is accepted only while no ready pulse is outstanding.
    assign acc     = reg_valid_i & ~reg_ready_o;
    assign wr      = acc & reg_we_i;
    assign wdata_g = reg_wdata_i[GPIO_NUM-1:0];
    assign unused_wdata = ^reg_wdata_i;

    assign gpio_out_o = do_r;
    assign gpio_oe_o  = oe_r;

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_WIDTH-1:0] deb_r;
    logic [DEB_WIDTH-1:0] cnt_r   [GPIO_NUM];
    logic [DEB_WIDTH-1:0] cnt_nxt [GPIO_NUM];

    // ">=" lets a counter left above a freshly lowered threshold commit immediately.
    always_comb begin
        stable_nxt = stable_r;
        for (int n = 0; n < GPIO_NUM; n++) begin
            cnt_nxt[n] = '0;
            if (sync2_r[n] != stable_r[n]) begin
                if (cnt_r[n] >= deb_r) begin
                    stable_nxt[n] = sync2_r[n];
                end else begin
                    cnt_nxt[n] = cnt_r[n] + DEB_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_r <= '0;
            for (int n = 0; n < GPIO_NUM; n++) begin
                cnt_r[n] <= '0;
            end
        end else begin
            if (wr && reg_addr_i == A_DEB) begin
                deb_r <= reg_wdata_i[DEB_WIDTH-1:0];
            end
            cnt_r <= cnt_nxt;
        end
    end

    assign deb_rd = 32'(deb_r);
`else
    assign stable_nxt = sync2_r;
    assign deb_rd     = '0;
`endif

    // DI reads the stable vector; events are taken on its transitions.
    assign edge_ev = ((stable_nxt & ~stable_r) & edge_r) |
                     ((~stable_nxt & stable_r) & ~edge_r);
    assign ip_clr  = (wr && reg_addr_i == A_IP) ? wdata_g : '0;

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            A_DO:    rd_mux = 32'(do_r);
            A_OE:    rd_mux = 32'(oe_r);
            A_DI:    rd_mux = 32'(stable_r);
            A_IE:    rd_mux = 32'(ie_r);
            A_IP:    rd_mux = 32'(ip_r);
            A_EDGE:  rd_mux = 32'(edge_r);
            A_DEB:   rd_mux = deb_rd;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_r     <= '0;
            sync2_r     <= '0;
            stable_r    <= '0;
            do_r        <= '0;
            oe_r        <= '0;
            ie_r        <= '0;
            ip_r        <= '0;
            edge_r      <= '1;
            irq_o       <= 1'b0;
            reg_ready_o <= 1'b0;
            reg_rdata_o <= '0;
        end else begin
            sync1_r     <= gpio_in_i;
            sync2_r     <= sync1_r;
            stable_r    <= stable_nxt;
            // A new event wins over a simultaneous write-one-to-clear.
            ip_r        <= (ip_r & ~ip_clr) | edge_ev;
            irq_o       <= |(ip_r & ie_r);
            reg_ready_o <= acc;
            reg_rdata_o <= (acc && !reg_we_i) ? rd_mux : '0;
            if (wr) begin
                case (reg_addr_i)
                    A_DO:    do_r   <= wdata_g;
                    A_OE:    oe_r   <= wdata_g;
                    A_IE:    ie_r   <= wdata_g;
                    A_EDGE:  edge_r <= wdata_g;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fpga_gpio_bank.sv
// Self-checking bench for fpga_gpio_bank with a queue-based reference model of synchroniser, debounce and IP.
module tb_fpga_gpio_bank;
    localparam int N = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DEB_T = 4;
`else
    localparam int DEB_T = 0;
`endif
    localparam int L = 3 + DEB_T;

    logic          clk, rst;
    logic          reg_valid, reg_we, reg_ready, irq;
    logic [2:0]    reg_addr;
    logic [31:0]   reg_wdata, reg_rdata;
    logic [N-1:0]  gpio_in, gpio_out, gpio_oe;
    int            n_tests, n_fail;

    fpga_gpio_bank #(.GPIO_NUM(N), .DEB_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_valid_i(reg_valid), .reg_ready_o(reg_ready), .reg_we_i(reg_we),
        .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata),
        .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe), .irq_o(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model: DI flips once the synchronised pad has disagreed with it for DEB+1 consecutive cycles.
    logic [N-1:0]  m_do, m_oe, m_ie, m_ip, m_edge, m_stable;
    int            m_deb;
    bit            m_irq, m_ready;
    logic [31:0]   m_rdata;
    logic [N-1:0]  pad_q[$];
    logic [N-1:0]  syn_q[$];

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_do);
            3'd1: return 32'(m_oe);
            3'd2: return 32'(m_stable);
            3'd3: return 32'(m_ie);
            3'd4: return 32'(m_ip);
            3'd5: return 32'(m_edge);
`ifdef GPIO_DEBOUNCE_EN
            3'd6: return 32'(m_deb);
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_do = '0; m_oe = '0; m_ie = '0; m_ip = '0; m_edge = '1; m_stable = '0;
            m_deb = 0; m_irq = 0; m_ready = 0; m_rdata = '0;
            pad_q.delete();
            syn_q.delete();
        end else begin
            logic [N-1:0] syn, nxt, rise, fall, clr;
            bit acc;
            int need, run;
            syn = (pad_q.size() >= 2) ? pad_q[1] : '0;
            pad_q.push_front(gpio_in);
            if (pad_q.size() > 4) void'(pad_q.pop_back());
            syn_q.push_front(syn);
            if (syn_q.size() > 40) void'(syn_q.pop_back());
`ifdef GPIO_DEBOUNCE_EN
            need = m_deb + 1;
`else
            need = 1;
`endif
            nxt = m_stable;
            for (int c = 0; c < N; c++) begin
                run = 0;
                while (run < need && run < syn_q.size() && syn_q[run][c] != m_stable[c]) run++;
                if (run >= need) nxt[c] = ~m_stable[c];
            end
            rise = nxt & ~m_stable;
            fall = ~nxt & m_stable;
            acc = reg_valid && !m_ready;
            m_rdata = (acc && !reg_we) ? m_read(reg_addr) : 32'd0;
            m_irq = |(m_ip & m_ie);
            clr = (acc && reg_we && reg_addr == 3'd4) ? reg_wdata[N-1:0] : '0;
            m_ip = (m_ip & ~clr) | (rise & m_edge) | (fall & ~m_edge);
            if (acc && reg_we) begin
                case (reg_addr)
                    3'd0: m_do = reg_wdata[N-1:0];
                    3'd1: m_oe = reg_wdata[N-1:0];
                    3'd3: m_ie = reg_wdata[N-1:0];
                    3'd5: m_edge = reg_wdata[N-1:0];
                    3'd6: m_deb = int'(reg_wdata[15:0]);
                    default: ;
                endcase
            end
            m_stable = nxt;
            m_ready = acc;
        end
    end

    always @(negedge clk) begin
        chk("mon_ready", 32'(reg_ready), 32'(m_ready));
        chk("mon_rdata", reg_rdata, m_rdata);
        chk("mon_gpio_out", 32'(gpio_out), 32'(m_do));
        chk("mon_gpio_oe", 32'(gpio_oe), 32'(m_oe));
        chk("mon_irq", 32'(irq), 32'(m_irq));
    end

    task automatic bus(input bit we, input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
        @(posedge clk); #2;
        reg_valid = 1'b1; reg_we = we; reg_addr = a; reg_wdata = wd;
        @(posedge clk); #2;
        chk("bus_ready", 32'(reg_ready), 32'd1);
        rd = reg_rdata;
        reg_valid = 1'b0; reg_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        logic [31:0] d;
        bus(1'b1, a, wd, d);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, a, 32'd0, d);
        chk(tag, d, exp);
    endtask

    task automatic ticks(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    // Raise pad 3 (optionally dropping it after 'width' cycles) and read DI with its capture edge 'cap' cycles later.
    task automatic di_probe(input string tag, input int width, input int cap, input logic [31:0] exp);
        @(posedge clk); #2;
        gpio_in[3] = 1'b1;
        for (int i = 1; i < cap; i++) begin
            @(posedge clk); #2;
            if (i == width) gpio_in[3] = 1'b0;
            if (i == cap - 1) begin
                reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 3'd2;
            end
        end
        @(posedge clk); #2;
        chk(tag, reg_rdata & 32'h8, exp);
        reg_valid = 1'b0;
        gpio_in[3] = 1'b0;
        ticks(L + 4);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reg_valid = 0; reg_we = 0; reg_addr = '0; reg_wdata = '0; gpio_in = '0; rst = 0;
        #1 rst = 1'b1;
        #3;
        chk("rst_ready", 32'(reg_ready), 32'd0);
        chk("rst_rdata", reg_rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        rd_chk("edge_reset", 3'd5, 32'h0000_FFFF);
        rd_chk("do_reset", 3'd0, 32'd0);
        rd_chk("di_reset", 3'd2, 32'd0);
        rd_chk("ip_reset", 3'd4, 32'd0);

        // Pad drive and register readback
        wr(3'd1, 32'h0000_00FF);
        wr(3'd0, 32'h0000_00A5);
        chk("pad_oe", 32'(gpio_oe), 32'h0000_00FF);
        chk("pad_out", 32'(gpio_out), 32'h0000_00A5);
        rd_chk("do_read", 3'd0, 32'h0000_00A5);
        wr(3'd0, 32'hFFFF_00A5);
        rd_chk("do_upper_masked", 3'd0, 32'h0000_00A5);
        wr(3'd7, 32'hFFFF_FFFF);
        rd_chk("addr7_zero", 3'd7, 32'd0);

        // Debounce threshold and DI latency
`ifdef GPIO_DEBOUNCE_EN
        wr(3'd6, 32'hABCD_0004);
        rd_chk("deb_read", 3'd6, 32'h0000_0004);
`else
        wr(3'd6, 32'h0000_0010);
        rd_chk("deb_read_zero", 3'd6, 32'd0);
`endif
        di_probe("di_before_latency", 0, L, 32'd0);
        di_probe("di_at_latency", 0, L + 1, 32'h8);
`ifdef GPIO_DEBOUNCE_EN
        di_probe("di_glitch_rejected", 3, L + 6, 32'd0);
`endif

        // Falling-edge interrupt on channel 0
        wr(3'd5, 32'h0000_FFFE);
        wr(3'd3, 32'h0000_0001);
        wr(3'd4, 32'hFFFF_FFFF);
        @(posedge clk); #2;
        gpio_in[0] = 1'b1;
        ticks(L + 4);
        rd_chk("ip_ignores_rise", 3'd4, 32'd0);
        chk("irq_no_rise", 32'(irq), 32'd0);
        @(posedge clk); #2;
        gpio_in[0] = 1'b0;
        for (int i = 1; i <= L + 2; i++) begin
            @(posedge clk); #2;
            chk("irq_fall_timing", 32'(irq), 32'(i >= L + 1));
        end
        rd_chk("ip_fall", 3'd4, 32'h0000_0001);
        wr(3'd4, 32'h0000_0001);
        chk("irq_hold_one_cycle", 32'(irq), 32'd1);
        @(posedge clk); #2;
        chk("irq_cleared", 32'(irq), 32'd0);
        rd_chk("ip_cleared", 3'd4, 32'd0);

        // w1c colliding with a new rising edge on channel 2
        wr(3'd5, 32'h0000_FFFF);
        wr(3'd4, 32'h0000_FFFF);
        @(posedge clk); #2;
        gpio_in[2] = 1'b1;
        ticks(L - 1);
        reg_valid = 1'b1; reg_we = 1'b1; reg_addr = 3'd4; reg_wdata = 32'h0000_0004;
        @(posedge clk); #2;
        chk("collide_ready", 32'(reg_ready), 32'd1);
        reg_valid = 1'b0; reg_we = 1'b0;
        rd_chk("ip_set_wins", 3'd4, 32'h0000_0004);
        wr(3'd4, 32'h0000_0004);
        rd_chk("ip_w1c", 3'd4, 32'd0);

        // Reset in the middle of a read
        wr(3'd5, 32'h0000_FFFB);
        gpio_in[2] = 1'b0;
        ticks(L + 4);
        wr(3'd3, 32'h0000_0004);
        @(posedge clk); #2;
        reg_valid = 1'b1; reg_we = 1'b0; reg_addr = 3'd0;
        @(posedge clk); #2;
        chk("pre_rst_ready", 32'(reg_ready), 32'd1);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        gpio_in = 16'h0010;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(reg_ready), 32'd0);
        chk("mid_rst_rdata", reg_rdata, 32'd0);
        chk("mid_rst_out", 32'(gpio_out), 32'd0);
        chk("mid_rst_oe", 32'(gpio_oe), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        reg_valid = 1'b0;
        ticks(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk("no_ready_after_rst", 32'(reg_ready), 32'd0);
        end
        rd_chk("edge_after_rst", 3'd5, 32'h0000_FFFF);
        rd_chk("do_after_rst", 3'd0, 32'd0);
        ticks(L + 4);
        rd_chk("ip_pad_high_after_rst", 3'd4, 32'h0000_0010);
        rd_chk("di_pad_high_after_rst", 3'd2, 32'h0000_0010);

        // Randomised traffic against the model
        for (int it = 0; it < 300; it++) begin
            logic [31:0] d, wd;
            logic [2:0]  a;
            bit          we;
            @(posedge clk); #2;
            if ($urandom_range(0, 2) == 0)
                gpio_in = gpio_in ^ 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
            a  = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (a == 3'd6) wd = {wd[31:16], 16'($urandom_range(0, 5))};
            if (it % 10 == 0) begin
                reg_valid = 1'b1; reg_we = 1'b0; reg_addr = a; reg_wdata = 32'd0;
                @(posedge clk); #2;
                chk("b2b_first", 32'(reg_ready), 32'd1);
                reg_addr = 3'(a + 3'd1);
                @(posedge clk); #2;
                chk("b2b_gap", 32'(reg_ready), 32'd0);
                @(posedge clk); #2;
                chk("b2b_second", 32'(reg_ready), 32'd1);
                reg_valid = 1'b0;
            end else if ($urandom_range(0, 2) != 0) begin
                bus(we, a, wd, d);
            end
        end

        ticks(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpga_gpio_bank.md
FPGA_GPIO_BANK -- requirements
Module: fpga_gpio_bank

Interface
REQ-001 SHALL have parameter GPIO_NUM, default 16, number of GPIO channels (1..32).
REQ-002 SHALL have parameter DEB_WIDTH, default 16, width of the debounce threshold and counters (1..32).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is clocked on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port reg_valid_i, input, 1, register access request.
REQ-006 SHALL have port reg_ready_o, output, 1, access complete.
REQ-007 SHALL have port reg_we_i, input, 1, write (1) or read (0).
REQ-008 SHALL have port reg_addr_i, input, 3, word index into the register map.
REQ-009 SHALL have port reg_wdata_i, input, 32, write data.
REQ-010 SHALL have port reg_rdata_o, output, 32, read data.
REQ-011 SHALL have port gpio_in_i, input, GPIO_NUM, raw pad input (asynchronous).
REQ-012 SHALL have port gpio_out_o, output, GPIO_NUM, pad output data.
REQ-013 SHALL have port gpio_oe_o, output, GPIO_NUM, pad output enable (1 = drive).
REQ-014 SHALL have port irq_o, output, 1, registered level interrupt.

Function
REQ-015 SHALL implement this register map, where bits above GPIO_NUM read 0 and ignore writes:
- 0 DO: rw, drives gpio_out_o.
- 1 OE: rw, drives gpio_oe_o.
- 2 DI: ro, debounced input.
- 3 IE: rw, interrupt enable.
- 4 IP: rw1c, interrupt pending.
- 5 EDGE: rw; 1 = rising edge, 0 = falling edge.
- 6 DEB: rw, bits [DEB_WIDTH-1:0] hold the debounce threshold.
- 7: reads 0 and ignores writes.
REQ-016 SHALL handle accesses as follows:
- reg_ready_o pulses high exactly one cycle after a cycle with reg_valid_i=1 and reg_ready_o=0.
- reg_rdata_o is valid in that same cycle and is 0 in every other cycle.
- Writes take effect at the edge that raises reg_ready_o.
REQ-017 SHALL keep reg_valid_i asserted until reg_ready_o; back-to-back accesses complete every second cycle.
REQ-018 SHALL pass each gpio_in_i bit through a 2-flop synchroniser before any other use.
REQ-019 SHALL debounce each channel with its own counter against a stable value:
- Synchronised value equals stable: counter clears.
- Values differ and counter < DEB: counter increments.
- Values differ and counter == DEB: stable takes the new value and counter clears.
- DEB=0: stable follows the synchroniser output after 1 cycle.
REQ-020 SHALL latch DI from the stable values; pad-to-DI latency is 3+DEB cycles.
REQ-021 SHALL set IP[n] when stable[n] transitions in the direction selected by EDGE[n], regardless of IE.
REQ-022 SHALL give set priority when an edge event and a w1c clear hit the same IP bit in the same cycle (the bit stays 1).
REQ-023 SHALL register irq_o = |(IP & IE), so irq_o lags IP/IE by 1 cycle.
REQ-024 SHALL apply a DEB change at the next comparison; a counter already above the new DEB matches at ">=" and updates stable on the next cycle.

Reset
REQ-025 SHALL, while rst_i=1, asynchronously force the following, and nothing else:
- DO, OE, IE, IP, DEB, DI, stable values, counters and synchroniser flops to 0.
- EDGE to all 1.
- gpio_out_o, gpio_oe_o, irq_o, reg_ready_o and reg_rdata_o to 0.
REQ-026 SHALL abandon an access in flight when reset asserts; no ready pulse is produced for it after release.
REQ-027 SHALL, for the first cycles after release, keep stable at 0 and produce no edge event from reset values; a pad already high raises IP only if EDGE selects rising, after 3+DEB cycles.

Configuration
REQ-028 SHALL, with GPIO_DEBOUNCE_EN defined, implement the debounce counters and the DEB register as above.
REQ-029 SHALL, without GPIO_DEBOUNCE_EN:
- Omit the counters and the DEB storage.
- Make stable equal to the synchroniser output registered once, so pad-to-DI latency is 3 cycles.
- Read DEB as 0 and ignore writes to it.

Verification
REQ-030 SHALL cover write OE=0x0000_00FF then DO=0x0000_00A5 -> gpio_oe_o=0x00FF, gpio_out_o=0x00A5; read DO returns 0xA5 with reg_ready_o 1 cycle after valid.
REQ-031 SHALL cover DEB=4, gpio_in_i[3] 0->1 held -> DI[3]=1 exactly 7 cycles after the change; a 3-cycle glitch -> DI[3] stays 0.
REQ-032 SHALL cover IE[0]=1, EDGE[0]=0, pad 0 high then low -> IP[0]=1 only on the fall; irq_o=1 one cycle later; write IP=0x1 -> IP[0]=0, irq_o=0 next cycle.
REQ-033 SHALL cover a w1c of IP[2] coinciding with a new rising edge on channel 2 -> IP[2] reads 1.
REQ-034 SHALL cover rst_i asserted mid-read -> all outputs 0 within the same cycle, EDGE reads 0x0000_FFFF (GPIO_NUM=16), and no reg_ready_o pulse after release until a new request.
REQ-035 SHALL cover a build without GPIO_DEBOUNCE_EN: pad edge -> DI updates after 3 cycles; write DEB=0x10 -> DEB reads 0.
